level_sequencer: RTL
====================

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 NUM_LEVELS, 8, number of levels; level index runs 0..NUM_LEVELS-1.
REQ-002 DEAD_TICKS, 30, ticks spent in DEAD before respawn (valid range 1..255).
REQ-003 TRANS_TICKS, 15, ticks spent in TRANS before entering the next level (valid range 1..255).
REQ-004 START_X / START_Y, 160 / 250, spawn centre applied on every level entry, 10-bit.
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 tick  in  1  one-clk game-rate pulse, same rate as the player-motion update.
REQ-008 start  in  1  level-sensitive start/continue button.
REQ-009 xpos, ypos  in  10 each  current player centre in hCount/vCount coordinates.
REQ-010 hit_lava, hit_trans, hit_goal, hit_ckpt  in  1 each  player-overlap flags from the renderer.
REQ-011 state  out  3  IDLE=0, PLAY=1, DEAD=2, TRANS=3, WON=4.
REQ-012 level  out  3  current level index.
REQ-013 freeze  out  1  high whenever state != PLAY; movement logic holds position while high.
REQ-014 respawn  out  1  one-clk pulse; the position logic loads respawn_x/respawn_y on this pulse.
REQ-015 respawn_x, respawn_y  out  10 each  position to load; stable while respawn is high.
REQ-016 deaths  out  8  death counter, saturating.

Function
REQ-017 The block shall evaluate all state transitions only on clk edges where tick=1, except IDLE->PLAY and WON->IDLE, which act on any clk edge.
REQ-018 In IDLE, start=1 shall set level=0, set the checkpoint to (START_X,START_Y), pulse respawn with (START_X,START_Y), and enter PLAY on the same edge.
REQ-019 In PLAY with tick=1, flags shall be resolved in fixed priority hit_lava > hit_goal > hit_trans > hit_ckpt; only the highest asserted flag acts.
REQ-020 hit_lava shall enter DEAD, load timer=DEAD_TICKS, and increment deaths, saturating at 255.
REQ-021 hit_goal with level=NUM_LEVELS-1 shall enter WON; hit_goal on any other level shall behave as hit_trans.
REQ-022 hit_trans on level<NUM_LEVELS-1 shall enter TRANS and load timer=TRANS_TICKS; on the last level it shall be ignored.
REQ-023 hit_ckpt shall latch the checkpoint as (xpos,ypos) and remain in PLAY; repeated assertion overwrites the latched value.
REQ-024 In DEAD and TRANS, the timer shall decrement on each tick; at the tick where timer=1, the exit action shall occur: timer reaches 0 and state returns to PLAY.
REQ-025 DEAD exit shall pulse respawn with the checkpoint value; level is unchanged.
REQ-026 TRANS exit shall increment level, reset the checkpoint to (START_X,START_Y), and pulse respawn with (START_X,START_Y).
REQ-027 respawn shall be high for exactly one clk, registered on the same edge as the state change; respawn_x/respawn_y shall be held until the next respawn.
REQ-028 All hit_* flags shall be ignored outside PLAY.
REQ-029 In WON, the block shall wait for start=0, then start=1, then enter IDLE; deaths shall persist and clear only on rst.
REQ-030 The level shall never exceed NUM_LEVELS-1, and shall never wrap.

Reset
REQ-031 On rst, the block shall set state=IDLE, level=0, timer=0, deaths=0, respawn=0, respawn_x=START_X, respawn_y=START_Y, checkpoint=(START_X,START_Y), and freeze=1.
REQ-032 If rst asserts mid-DEAD or mid-TRANS, the block shall abort with no respawn pulse, and all values shall follow REQ-031 immediately.

Verification
REQ-033 Scenario 1: rst, then start=1 -> state=PLAY, one respawn pulse at (160,250), freeze=0.
REQ-034 Scenario 2: PLAY, hit_ckpt at (400,200), then hit_lava -> DEAD, deaths=1, freeze=1 for 30 ticks, then respawn at (400,200) and state=PLAY.
REQ-035 Scenario 3: hit_lava and hit_trans in the same tick -> DEAD; level unchanged.
REQ-036 Scenario 4: hit_trans on level 0 -> TRANS for 15 ticks, then level=1, respawn at (160,250), and the old checkpoint is discarded.
REQ-037 Scenario 5: advance to level 7, then hit_trans -> ignored; then hit_goal -> WON; start released and re-pressed -> IDLE.
REQ-038 Scenario 6: 300 lava deaths -> deaths=255; rst during DEAD at timer=12 -> IDLE with no respawn pulse.

Source files
------------

// File: rtl/level_sequencer.sv
// level_sequencer
// Game-flow controller: sequences a player through NUM_LEVELS levels,
// handling death/respawn delays, level transitions, checkpoints and the
// final win screen.
//
// Ports
//   clk, rst          system clock; asynchronous active-high reset
//   tick              one-clk game-rate pulse (paces all timed transitions)
//   start             level-sensitive start/continue button
//   xpos, ypos        current player centre (hCount/vCount coordinates)
//   hit_lava, hit_trans, hit_goal, hit_ckpt
//                     player-overlap flags from the renderer
//   state             IDLE=0, PLAY=1, DEAD=2, TRANS=3, WON=4
//   level             current level index
//   freeze            high whenever state != PLAY
//   respawn           one-clk pulse: position logic loads respawn_x/respawn_y
//   respawn_x/_y      position to load; held until the next respawn
//   deaths            saturating death counter
module level_sequencer #(
    parameter int          NUM_LEVELS  = 8,
    parameter int          DEAD_TICKS  = 30,
    parameter int          TRANS_TICKS = 15,
    parameter logic [9:0]  START_X     = 10'd160,
    parameter logic [9:0]  START_Y     = 10'd250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    input  logic        hit_lava,
    input  logic        hit_trans,
    input  logic        hit_goal,
    input  logic        hit_ckpt,
    output logic [2:0]  state,
    output logic [2:0]  level,
    output logic        freeze,
    output logic        respawn,
    output logic [9:0]  respawn_x,
    output logic [9:0]  respawn_y,
    output logic [7:0]  deaths
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_DEAD  = 3'd2,
        S_TRANS = 3'd3,
        S_WON   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);
    localparam logic [7:0] DEAD_LOAD  = 8'(DEAD_TICKS);
    localparam logic [7:0] TRANS_LOAD = 8'(TRANS_TICKS);

    state_t      cur;
    logic [7:0]  timer;
    logic [9:0]  ckpt_x;
    logic [9:0]  ckpt_y;
    logic        won_released;  // start has been seen low since entering WON

    assign state = cur;

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur          <= S_IDLE;
            level        <= 3'd0;
            timer        <= 8'd0;
            deaths       <= 8'd0;
            freeze       <= 1'b1;
            respawn      <= 1'b0;
            respawn_x    <= START_X;
            respawn_y    <= START_Y;
            ckpt_x       <= START_X;
            ckpt_y       <= START_Y;
            won_released <= 1'b0;
        end else begin
            // NOTE: respawn defaults low each clock; branches that respawn
            // override it, which makes it a single-clock pulse.
            respawn <= 1'b0;

            case (cur)
                // Start acts on any edge, not only on tick.
                S_IDLE: begin
                    if (start) begin
                        cur       <= S_PLAY;
                        freeze    <= 1'b0;
                        level     <= 3'd0;
                        ckpt_x    <= START_X;
                        ckpt_y    <= START_Y;
                        respawn   <= 1'b1;
                        respawn_x <= START_X;
                        respawn_y <= START_Y;
                    end
                end

                // Fixed priority: lava > goal > trans > ckpt. A trans/goal
                // that cannot advance still outranks a checkpoint.
                S_PLAY: begin
                    if (tick) begin
                        if (hit_lava) begin
                            cur    <= S_DEAD;
                            freeze <= 1'b1;
                            timer  <= DEAD_LOAD;
                            if (deaths != 8'hFF) deaths <= deaths + 8'd1;
                        end else if (hit_goal && level == LAST_LEVEL) begin
                            cur          <= S_WON;
                            freeze       <= 1'b1;
                            won_released <= 1'b0;
                        end else if (hit_goal || hit_trans) begin
                            if (level != LAST_LEVEL) begin
                                cur    <= S_TRANS;
                                freeze <= 1'b1;
                                timer  <= TRANS_LOAD;
                            end
                        end else if (hit_ckpt) begin
                            ckpt_x <= xpos;
                            ckpt_y <= ypos;
                        end
                    end
                end

                S_DEAD: begin
                    if (tick) begin
                        if (timer == 8'd1) begin
                            timer     <= 8'd0;
                            cur       <= S_PLAY;
                            freeze    <= 1'b0;
                            respawn   <= 1'b1;
                            respawn_x <= ckpt_x;
                            respawn_y <= ckpt_y;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                end

                S_TRANS: begin
                    if (tick) begin
                        if (timer == 8'd1) begin
                            timer     <= 8'd0;
                            cur       <= S_PLAY;
                            freeze    <= 1'b0;
                            if (level != LAST_LEVEL) level <= level + 3'd1;
                            ckpt_x    <= START_X;
                            ckpt_y    <= START_Y;
                            respawn   <= 1'b1;
                            respawn_x <= START_X;
                            respawn_y <= START_Y;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                end

                // Requires a full release/press of start so a button still
                // held from play does not skip the win screen.
                S_WON: begin
                    if (!start) begin
                        won_released <= 1'b1;
                    end else if (won_released) begin
                        cur <= S_IDLE;
                    end
                end

                default: begin
                    cur    <= S_IDLE;
                    freeze <= 1'b1;
                end
            endcase
        end
    end

endmodule
